// File: rtl/ice_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ice_uart_tx_arbiter
//
// Shares the single host-facing UART transmitter between the ICE response
// sources (ACK/NAK generator, MBUS Rx forwarder, GPIO/PMU event reporters).
// Arbitration is packet-atomic round-robin: once a requester is granted it
// keeps the UART until the last byte of its packet has completely left the
// transmitter, so frames from different sources never interleave.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-high reset
//   req_valid      per-requester byte valid
//   req_data       per-requester byte, requester i on req_data[8i+:8]
//   req_last       presented byte is the final byte of its packet
//   req_ready      byte accepted this cycle (valid & ready = transfer)
//   uart_tx_latch  one-cycle load strobe to the UART
//   uart_tx_data   byte to the UART, held until the next strobe
//   uart_tx_empty  UART transmitter idle
//   grant_id       current owner (meaningful while busy)
//   busy           a packet is in progress
//   timeout_pulse  one-cycle pulse when a stalled grant is revoked
// ---------------------------------------------------------------------------
module ice_uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       uart_tx_latch,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_tx_empty,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_pulse
);

    localparam int DATA_W = 8;
    localparam int GW     = $clog2(NUM_REQ);
    localparam int GCW    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    // Width of 1 when the timeout is disabled keeps the counter legal.
    localparam int TOW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [GCW-1:0] GUARD_LAST = GCW'(GUARD_CYC - 1);
    localparam logic [TOW-1:0] TO_LIMIT   = TOW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic            last_flag;
    logic [GCW-1:0]  guard_cnt;
    logic [TOW-1:0]  to_cnt;
    logic [TOW-1:0]  to_nxt;
    logic [GW-1:0]   pick;
    logic            xfer;
    logic [DATA_W-1:0] grant_byte;

    // First valid requester strictly after ptr, wrapping. The previous owner
    // is examined last, which is what pushes it behind everyone else.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] sel;
        logic [GW-1:0] idx;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(ptr) + k) % NUM_REQ);
            if (!found && v[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Saturating increment: the stall counter must never wrap back to zero.
    function automatic logic [TOW-1:0] sat_inc(input logic [TOW-1:0] c);
        if (&c) begin
            return c;
        end
        return c + TOW'(1);
    endfunction

    assign pick       = rr_pick(req_valid, rr_ptr);
    assign to_nxt     = sat_inc(to_cnt);
    assign grant_byte = req_data[{grant_id, 3'b000} +: DATA_W];
    assign xfer       = (state == SEND) && req_valid[grant_id] && uart_tx_empty;

    // Only the owner may see ready, and only while the UART can take a byte.
    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            req_ready[grant_id] = req_valid[grant_id] & uart_tx_empty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= GW'(NUM_REQ - 1);
            grant_id      <= '0;
            busy          <= 1'b0;
            uart_tx_latch <= 1'b0;
            uart_tx_data  <= '0;
            last_flag     <= 1'b0;
            guard_cnt     <= '0;
            to_cnt        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            uart_tx_latch <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
                        to_cnt   <= '0;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (xfer) begin
                        uart_tx_data  <= grant_byte;
                        uart_tx_latch <= 1'b1;
                        last_flag     <= req_last[grant_id];
                        to_cnt        <= '0;
                        guard_cnt     <= '0;
                        state         <= GUARD;
                    end else if (!req_valid[grant_id]) begin
                        // Owner went quiet mid-packet; revoke once the stall
                        // reaches the limit. The partial frame is left as is.
                        if ((TIMEOUT_CYC != 0) && (to_nxt == TO_LIMIT)) begin
                            timeout_pulse <= 1'b1;
                            rr_ptr        <= grant_id;
                            busy          <= 1'b0;
                            to_cnt        <= '0;
                            state         <= IDLE;
                        end else begin
                            to_cnt <= to_nxt;
                        end
                    end
                end

                // tx_empty lags the latch by a few cycles inside the UART, so
                // it is not trusted until the guard interval has passed.
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        guard_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        guard_cnt <= guard_cnt + GCW'(1);
                    end
                end

                DRAIN: begin
                    if (uart_tx_empty) begin
                        if (last_flag) begin
                            rr_ptr <= grant_id;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ice_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ice_uart_tx_arbiter
//
// Directed bench for ice_uart_tx_arbiter. Each requester is a queue of
// {last,data} entries; a small UART model drops tx_empty for a fixed number
// of cycles after every latch. Every latched byte is logged as id*256+data
// with the cycle it was seen, and compared against hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ice_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int TO     = 16;
    localparam int TX_CYC = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              uart_tx_latch;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_empty;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_pulse;

    logic              force_full;
    int                busy_cnt;

    ice_uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .GUARD_CYC  (2),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_latch(uart_tx_latch),
        .uart_tx_data (uart_tx_data),
        .uart_tx_empty(uart_tx_empty),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for TX_CYC cycles after the cycle carrying the latch.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (uart_tx_latch) begin
            busy_cnt <= TX_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign uart_tx_empty = (busy_cnt == 0) && !force_full;

    logic [8:0]      srcq [NREQ][$];
    logic [NREQ-1:0] hs;
    int              log_e [$];
    int              log_c [$];
    int              cyc, total, bad, viol, tp_cnt, tp_cyc, fall_cyc, t0, nconsec;
    logic            busy_q;
    logic [NREQ-1:0] ready_seen;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int get_e(input int k);
        return (k < log_e.size()) ? log_e[k] : -1;
    endfunction

    function automatic int get_c(input int k);
        return (k < log_c.size()) ? log_c[k] : -1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic last);
        srcq[r].push_back({last, d});
    endtask

    task automatic resample();
        #1;
        hs = reset ? '0 : (req_valid & req_ready);
    endtask

    // One clock: retire handshakes from the previous edge, observe outputs,
    // then present the next head of each source queue.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
            end
        end
        if (uart_tx_latch) begin
            log_e.push_back(int'(grant_id) * 256 + int'(uart_tx_data));
            log_c.push_back(cyc);
            if (busy_cnt != 0) viol++;
        end
        if (timeout_pulse) begin
            tp_cnt++;
            tp_cyc = cyc;
        end
        if (busy_q && !busy) fall_cyc = cyc;
        busy_q = busy;
        if ((req_ready & ~req_valid) != '0) viol++;
        if ((|req_ready) && !uart_tx_empty) viol++;
        ready_seen = ready_seen | req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0) begin
                e = srcq[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        resample();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        log_e.delete();
        log_c.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hs    = '0;
        for (int i = 0; i < NREQ; i++) srcq[i].delete();
        run(2);
        reset  = 1'b0;
        busy_q = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        force_full = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        hs         = '0;
        busy_q     = 1'b0;
        ready_seen = '0;
        cyc = 0; total = 0; bad = 0; viol = 0;
        tp_cnt = 0; tp_cyc = 0; fall_cyc = 0; nconsec = 0;
        run(3);

        // Reset state
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_latch", int'(uart_tx_latch), 0);
        chk("rst_data",  int'(uart_tx_data), 0);
        chk("rst_grant", int'(grant_id), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_tout",  int'(timeout_pulse), 0);
        reset = 1'b0;

        // 1: single 3-byte packet from req0
        clear_log();
        push(0, 8'h00, 1'b0);
        push(0, 8'h05, 1'b0);
        push(0, 8'h00, 1'b1);
        t0 = cyc;
        run(40);
        chk("t1_count", log_e.size(), 3);
        chk("t1_b0", get_e(0), 'h000);
        chk("t1_b1", get_e(1), 'h005);
        chk("t1_b2", get_e(2), 'h000);
        chk("t1_latency", get_c(0), t0 + 3);
        chk("t1_b1_spacing", get_c(1) - get_c(0), 7);
        chk("t1_busy_fall", fall_cyc - get_c(2), 6);
        chk("t1_busy_end", int'(busy), 0);

        // 2: collision req0 vs req2 from reset
        do_reset();
        clear_log();
        push(0, 8'h00, 1'b0); push(0, 8'h07, 1'b0); push(0, 8'h00, 1'b1);
        push(2, 8'h62, 1'b0); push(2, 8'h0c, 1'b0); push(2, 8'h08, 1'b1);
        run(60);
        chk("t2_count", log_e.size(), 6);
        chk("t2_b0", get_e(0), 'h000);
        chk("t2_b1", get_e(1), 'h007);
        chk("t2_b2", get_e(2), 'h000);
        chk("t2_b3", get_e(3), 'h262);
        chk("t2_b4", get_e(4), 'h20c);
        chk("t2_b5", get_e(5), 'h208);

        // 3: fairness between req1 and req3 single-byte packets
        do_reset();
        clear_log();
        push(1, 8'ha1, 1'b1); push(1, 8'ha2, 1'b1); push(1, 8'ha3, 1'b1);
        push(3, 8'hb1, 1'b1); push(3, 8'hb2, 1'b1); push(3, 8'hb3, 1'b1);
        run(90);
        chk("t3_count", log_e.size(), 6);
        chk("t3_p0", get_e(0), 'h1a1);
        chk("t3_p1", get_e(1), 'h3b1);
        chk("t3_p2", get_e(2), 'h1a2);
        chk("t3_p3", get_e(3), 'h3b2);
        chk("t3_p4", get_e(4), 'h1a3);
        chk("t3_p5", get_e(5), 'h3b3);
        nconsec = 0;
        for (int k = 1; k < log_e.size(); k++) begin
            if ((log_e[k] >> 8) == (log_e[k-1] >> 8)) nconsec++;
        end
        chk("t3_no_repeat", nconsec, 0);

        // 4: req1 stalls mid-packet, req2 waiting
        clear_log();
        tp_cnt = 0;
        push(1, 8'h3c, 1'b0);
        push(2, 8'h5a, 1'b1);
        run(60);
        chk("t4_count", log_e.size(), 2);
        chk("t4_b0", get_e(0), 'h13c);
        chk("t4_b1", get_e(1), 'h25a);
        chk("t4_pulses", tp_cnt, 1);
        chk("t4_pulse_time", tp_cyc - get_c(0), 22);
        chk("t4_req2_latch", get_c(1), tp_cyc + 2);

        // 5: reset during GUARD of byte 2 of 4
        clear_log();
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b0); push(0, 8'h44, 1'b1);
        for (int k = 0; k < 60 && log_e.size() < 2; k++) step();
        chk("t5_reached_b2", log_e.size(), 2);
        reset = 1'b1;
        hs    = '0;
        #1;
        chk("t5_ready", int'(req_ready), 0);
        chk("t5_latch", int'(uart_tx_latch), 0);
        chk("t5_data",  int'(uart_tx_data), 0);
        chk("t5_grant", int'(grant_id), 0);
        chk("t5_busy",  int'(busy), 0);
        chk("t5_tout",  int'(timeout_pulse), 0);
        for (int i = 0; i < NREQ; i++) srcq[i].delete();
        run(3);
        chk("t5_no_stray", log_e.size(), 2);
        reset  = 1'b0;
        busy_q = 1'b0;
        clear_log();
        push(3, 8'h77, 1'b1);
        push(0, 8'h99, 1'b1);
        run(30);
        chk("t5_first", get_e(0), 'h099);
        chk("t5_second", get_e(1), 'h377);

        // 6: UART never empty while in SEND
        clear_log();
        tp_cnt     = 0;
        force_full = 1'b1;
        ready_seen = '0;
        push(0, 8'he5, 1'b1);
        run(20);
        chk("t6_ready_gated", int'(ready_seen), 0);
        chk("t6_no_latch", log_e.size(), 0);
        chk("t6_busy", int'(busy), 1);
        chk("t6_grant", int'(grant_id), 0);
        force_full = 1'b0;
        resample();
        run(20);
        chk("t6_count", log_e.size(), 1);
        chk("t6_b0", get_e(0), 'h0e5);
        chk("t6_no_timeout", tp_cnt, 0);

        chk("protocol_viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
